// File: rtl/seq_cla_adder_pkg.sv
// seq_cla_adder_pkg: shared FSM encoding, default sizing and the flattened lookahead carry function.
package seq_cla_adder_pkg;
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_GROUP = 4;
  localparam int N = DEF_WIDTH / DEF_GROUP;
  localparam int MAX_GROUP = 16;
  function automatic int cnt_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  localparam int CW = cnt_w(N);
  // Each carry is a sum of products over p/g/c0 only, so no carry depends on another carry.
  function automatic logic [MAX_GROUP:0] cla_carries(input logic [MAX_GROUP-1:0] p, input logic [MAX_GROUP-1:0] g, input logic c0);
    logic [MAX_GROUP:0] c;
    logic t;
    c = '0;
    c[0] = c0;
    for (int i = 0; i < MAX_GROUP; i++) begin
      t = c0;
      for (int j = 0; j <= i; j++) t = t & p[j];
      c[i+1] = t;
      for (int j = 0; j <= i; j++) begin
        t = g[j];
        for (int m = j + 1; m <= i; m++) t = t & p[m];
        c[i+1] = c[i+1] | t;
      end
    end
    return c;
  endfunction
endpackage

// File: rtl/seq_cla_adder_lcu.sv
// cla_lcu: combinational GROUP-bit lookahead carry unit with group propagate/generate.
module cla_lcu
  import seq_cla_adder_pkg::*;
#(
  parameter int GROUP = DEF_GROUP
) (
  input  logic [GROUP-1:0] p_i,
  input  logic [GROUP-1:0] g_i,
  input  logic             c0_i,
  output logic [GROUP:1]   c_o,
  output logic             group_p_o,
  output logic             group_g_o
);
  assign c_o       = GROUP'(cla_carries(MAX_GROUP'(p_i), MAX_GROUP'(g_i), c0_i) >> 1);
  assign group_p_o = &p_i;
  assign group_g_o = 1'(cla_carries(MAX_GROUP'(p_i), MAX_GROUP'(g_i), 1'b0) >> GROUP);
endmodule

// File: rtl/seq_cla_adder.sv
// seq_cla_adder: multi-cycle add/subtract resolving one GROUP-bit slice per clock through a lookahead unit.
module seq_cla_adder
  import seq_cla_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int GROUP = DEF_GROUP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  input  logic             sub_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             ovf_o
);
  localparam int NS = WIDTH / GROUP;
  localparam int KW = cnt_w(NS);
  state_e state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, sum_q, sum_d, acc_m;
  logic c_q, c_d, cout_q, cout_d, ovf_q, ovf_d, done_q, done_d;
  logic [GROUP-1:0] a_s, b_s, s_s;
  logic [GROUP:1] c_l;
  logic [GROUP:0] cv;
  logic gp, gg, last;
  assign a_s  = GROUP'(a_q >> (int'(k_q) * GROUP));
  assign b_s  = GROUP'(b_q >> (int'(k_q) * GROUP));
  assign cv   = {c_l, c_q};
  // Sum uses XOR of the operands; P is the inclusive OR and would be wrong here.
  assign s_s  = a_s ^ b_s ^ cv[GROUP-1:0];
  assign acc_m = acc_q | (WIDTH'(s_s) << (int'(k_q) * GROUP));
  assign last = k_q == KW'(NS - 1);
  cla_lcu #(.GROUP(GROUP)) u_lcu (
    .p_i      (a_s | b_s),
    .g_i      (a_s & b_s),
    .c0_i     (c_q),
    .c_o      (c_l),
    .group_p_o(gp),
    .group_g_o(gg)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      c_q     <= c_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    c_d     = c_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    if (state_q == IDLE) begin
      if (start_i) begin
        state_d = RUN;
        a_d     = a_i;
        b_d     = b_i ^ {WIDTH{sub_i}};
        c_d     = sub_i | cin_i;
        k_d     = '0;
        acc_d   = '0;
      end
    end else begin
      acc_d = acc_m;
      c_d   = gg | (gp & c_q);
      k_d   = last ? '0 : k_q + 1'b1;
      if (last) begin
        sum_d   = acc_m;
        cout_d  = c_l[GROUP];
        ovf_d   = cv[GROUP] ^ cv[GROUP-1];
        done_d  = 1'b1;
        state_d = IDLE;
      end
    end
  end
  assign busy_o = state_q == RUN;
  assign done_o = done_q;
  assign sum_o  = sum_q;
  assign cout_o = cout_q;
  assign ovf_o  = ovf_q;
endmodule

// File: tb/tb_seq_cla_adder.sv
// tb_seq_cla_adder: scoreboard bench comparing the sequential adder with an arithmetic reference model.
module tb_seq_cla_adder;
  localparam int W = 16;
  localparam int G = 4;
  localparam int NS = W / G;
  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    int           e0;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_i = 1'b0;
  logic [W-1:0] a_i = '0, b_i = '0;
  logic cin_i = 1'b0, sub_i = 1'b0;
  logic busy_o, done_o, cout_o, ovf_o;
  logic [W-1:0] sum_o;
  int errors = 0, checks = 0, cyc = 0;
  exp_t q[$];
  logic [W-1:0] held_sum = '0;
  logic held_cout = 1'b0, held_ovf = 1'b0, prev_done = 1'b0;
  seq_cla_adder #(.WIDTH(W), .GROUP(G)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .a_i(a_i), .b_i(b_i), .cin_i(cin_i),
    .sub_i(sub_i), .busy_o(busy_o), .done_o(done_o), .sum_o(sum_o), .cout_o(cout_o), .ovf_o(ovf_o)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, req, cyc);
    end
  endtask
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci, input logic sb);
    exp_t e;
    logic [W-1:0] bb;
    logic [W:0] t;
    bb = sb ? ~b : b;
    t = {1'b0, a} + {1'b0, bb} + (W+1)'(sb | ci);
    e.sum = t[W-1:0];
    e.cout = t[W];
    e.ovf = (a[W-1] == bb[W-1]) && (t[W-1] != a[W-1]);
    e.e0 = 0;
    return e;
  endfunction
  always @(negedge clk) begin
    if (rst) begin
      held_sum = '0; held_cout = 1'b0; held_ovf = 1'b0; prev_done = 1'b0;
    end else begin
      if (done_o) begin
        chk("done_single", {31'b0, prev_done}, 0);
        chk("busy_at_done", {31'b0, busy_o}, 0);
        if (q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          exp_t e;
          e = q.pop_front();
          chk("sum", {16'b0, sum_o}, {16'b0, e.sum});
          chk("cout", {31'b0, cout_o}, {31'b0, e.cout});
          chk("ovf", {31'b0, ovf_o}, {31'b0, e.ovf});
          chk("latency", cyc - e.e0, NS);
        end
        held_sum = sum_o; held_cout = cout_o; held_ovf = ovf_o;
      end else if (busy_o) begin
        chk("held_result", {14'b0, held_cout, held_ovf, sum_o}, {14'b0, cout_o, ovf_o, held_sum});
      end
      prev_done = done_o;
    end
  end
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci, input logic sb, input bit expect_it);
    int n = 0;
    exp_t e;
    @(negedge clk);
    while (busy_o && n < 100) begin @(negedge clk); n++; end
    if (busy_o) chk("idle_timeout", 1, 0);
    a_i = a; b_i = b; cin_i = ci; sub_i = sb; start_i = 1'b1;
    if (expect_it) begin
      e = model(a, b, ci, sb);
      e.e0 = cyc + 1;
      q.push_back(e);
    end
    @(posedge clk);
    #1 start_i = 1'b0;
  endtask
  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin @(negedge clk); n++; end
    if (q.size() != 0) chk("drain_timeout", q.size(), 0);
    @(negedge clk);
  endtask
  initial begin
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_outs", {12'b0, busy_o, done_o, cout_o, ovf_o, sum_o}, 0);
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_outs", {12'b0, busy_o, done_o, cout_o, ovf_o, sum_o}, 0);
    end
    issue(16'h1234, 16'h4321, 1'b0, 1'b0, 1);
    for (int i = 0; i < NS - 1; i++) begin
      @(negedge clk);
      chk("busy_run", {31'b0, busy_o}, 1);
    end
    drain();
    issue(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1);
    issue(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1);
    issue(16'h0005, 16'h0007, 1'b1, 1'b1, 1);
    issue(16'h8000, 16'h0001, 1'b0, 1'b1, 1);
    drain();
    issue(16'h0F0F, 16'h1111, 1'b1, 1'b0, 1);
    @(posedge clk);
    #1 a_i = 16'hAAAA; b_i = 16'h5555; start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    issue(16'h2222, 16'h3333, 1'b0, 1'b1, 1);
    issue(16'h8001, 16'h8001, 1'b0, 1'b0, 1);
    drain();
    issue(16'hC0DE, 16'h1234, 1'b0, 1'b0, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_outs", {12'b0, busy_o, done_o, cout_o, ovf_o, sum_o}, 0);
    for (int i = 0; i < NS + 2; i++) begin
      @(negedge clk);
      chk("abort_no_done", {31'b0, done_o}, 0);
    end
    issue(16'h00FF, 16'h0001, 1'b0, 1'b0, 1);
    drain();
    for (int i = 0; i < 150; i++) begin
      int gap;
      gap = $urandom_range(0, 3);
      for (int j = 0; j < gap; j++) @(negedge clk);
      issue(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1);
    end
    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/seq_cla_adder.md
Name: seq_cla_adder

Overview:
- Multi-cycle WIDTH-bit adder/subtractor that consumes per-bit propagate/generate terms through a carry-lookahead unit.
- Acts as the carry-network end of the per-bit adder cell, which produces S, P (inclusive OR) and G (AND).
- Processes one GROUP-bit slice per clock and registers the group carry-out between slices.
- Start/done handshake toward the datapath controller of the adder/multiplier exercises.

Parameters:
WIDTH, 16, operand/result width; must be a multiple of GROUP
GROUP, 4, bits resolved per cycle by the lookahead unit

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous reset, active-high
start  in  1  request; sampled only when idle
a  in  WIDTH  operand A, captured on accepted start
b  in  WIDTH  operand B, captured on accepted start
cin  in  1  carry-in, captured on accepted start; ignored when sub=1
sub  in  1  1 = compute a - b, captured on accepted start
busy  out  1  high while a computation is in progress
done  out  1  one-cycle pulse, result valid
sum  out  WIDTH  result, held until the next completion
cout  out  1  carry out of bit WIDTH-1
ovf  out  1  two's-complement overflow

Behaviour:
- Interface: one clock; reset is synchronous and active-high (clk, rst).
- Reset: state=IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, slice counter=0.
- Derived constant: N = WIDTH/GROUP.
- FSM states: IDLE, RUN.
- IDLE, start=1 at edge E0:
  - latch a.
  - latch b^{WIDTH{sub}}.
  - latch carry register c = sub ? 1 : cin.
  - set k=0, go to RUN, busy=1.
- RUN, each edge E1..EN, for slice k (bits k*GROUP+GROUP-1 .. k*GROUP):
  - p_i = a_i|b_i, g_i = a_i&b_i.
  - Lookahead: c_0 = c; c_(i+1) = g_i | p_i&c_i, flattened two-level, no ripple.
  - s_i = a_i^b_i^c_i. Never use p_i for the sum, because P is the inclusive OR.
  - Write slice bits into the internal accumulator, set c <= c_GROUP, k <= k+1.
- At EN (k = N-1), registered at that edge:
  - sum <= accumulator with the final slice merged in.
  - cout <= c_GROUP of the last slice.
  - ovf <= c_GROUP ^ c_(GROUP-1) of the last slice.
  - done <= 1 for exactly one cycle, busy <= 0, state <= IDLE.
- Latency: done is high in the cycle after edge E_N, i.e. N edges after the start edge.
- sum/cout/ovf change only at completion. They are not disturbed by partial slices.
- start while busy=1: ignored, no effect on the current operation.
- start high in the same cycle as done: accepted (state is IDLE). Back-to-back throughput is one result per N+1 cycles.
- start held high continuously: a new operation begins each time IDLE is re-entered.
- rst at any time, including mid-RUN: abort and return to reset values. No done pulse for the aborted operation.
- Counter width: clog2(N), minimum 1. k never exceeds N-1.

Decomposition:
- Shared package:
  - FSM state encoding (IDLE=0, RUN=1).
  - derived localparams N and counter width.
  - function computing GROUP-wide carries from (p, g, c0).
- Sub-module cla_lcu: combinational lookahead carry unit.
  - Inputs: p[GROUP], g[GROUP], c0.
  - Outputs: c[GROUP:1], group_p = &p, group_g.
  - group_p/group_g are provided for future two-level use.
- Top-level seq_cla_adder contains the FSM, slice mux/demux, carry register and output registers.

Test Plan:
1. Reset while idle -> all outputs 0 for ≥3 cycles with start=0; busy never rises.
2. a=0x1234, b=0x4321, cin=0, sub=0 -> busy=1 for 4 cycles; done pulses once, 4 edges after start; sum=0x5555, cout=0, ovf=0.
3. a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0 (carry crosses all 4 slices). a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1.
4. sub=1, a=0x0005, b=0x0007, cin=1 (ignored) -> sum=0xFFFE, cout=0, ovf=0. sub=1, a=0x8000, b=0x0001 -> sum=0x7FFF, cout=1, ovf=1.
5. Handshake:
   - start pulsed again at E2 with different operands -> ignored; result of the first operation only.
   - start asserted in the done cycle -> accepted; second done follows 4 edges later.
6. rst asserted at E2 of an operation -> busy=0, done never pulses, sum/cout/ovf=0.
   - A following start with a=0x00FF, b=0x0001 yields sum=0x0100 with normal latency.
